// File: rtl/dis7seg_pkg.sv
// ---------------------------------------------------------------------------
// dis7seg_pkg
// Shared definitions for the multiplexed 7-segment driver:
//   - active-high segment patterns (bit0 = a .. bit6 = g) for 0-F, minus, blank
//   - 5-bit glyph codes understood by seg7_glyph (0-15 hex, 16 minus, 17 blank)
//   - conversion FSM state encoding
//   - double-dabble nibble adjust helper
// ---------------------------------------------------------------------------
package dis7seg_pkg;

  localparam int BCD_NIBBLES = 10;  // 32-bit magnitude needs 10 decimal digits

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_B     = 7'b1111100;  // lowercase b
  localparam logic [6:0] GLYPH_C     = 7'b0111001;
  localparam logic [6:0] GLYPH_D     = 7'b1011110;  // lowercase d
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_F     = 7'b1110001;
  localparam logic [6:0] GLYPH_MINUS = 7'b1000000;  // also used as the overflow dash
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam logic [4:0] CODE_MINUS = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_e;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [39:0] dabble_adjust(input logic [39:0] bcd);
    logic [39:0] r;
    r = bcd;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/dis7seg_mux_glyph.sv
// ---------------------------------------------------------------------------
// seg7_glyph
// Combinational glyph decoder. Output is always active-high; any pin polarity
// inversion is applied by the top level.
//   code    in  5  0-15 hex digit, 16 minus/dash, 17 blank (others blank)
//   pattern out 7  segment pattern, bit0 = a .. bit6 = g
// ---------------------------------------------------------------------------
module seg7_glyph
  import dis7seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pattern
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pattern = GLYPH_BLANK;
    case (code)
      5'd0:    pattern = GLYPH_0;
      5'd1:    pattern = GLYPH_1;
      5'd2:    pattern = GLYPH_2;
      5'd3:    pattern = GLYPH_3;
      5'd4:    pattern = GLYPH_4;
      5'd5:    pattern = GLYPH_5;
      5'd6:    pattern = GLYPH_6;
      5'd7:    pattern = GLYPH_7;
      5'd8:    pattern = GLYPH_8;
      5'd9:    pattern = GLYPH_9;
      5'd10:   pattern = GLYPH_A;
      5'd11:   pattern = GLYPH_B;
      5'd12:   pattern = GLYPH_C;
      5'd13:   pattern = GLYPH_D;
      5'd14:   pattern = GLYPH_E;
      5'd15:   pattern = GLYPH_F;
      5'd16:   pattern = GLYPH_MINUS;
      default: pattern = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/dis7seg_mux.sv
// ---------------------------------------------------------------------------
// dis7seg_mux
// Multiplexed 1..8 digit 7-segment driver. A sequential double-dabble FSM
// converts the 32-bit input (decimal or hex, optionally signed) and commits a
// full set of glyph codes to the display buffer in one cycle. A prescaled scan
// walks the digits; enables and segments are registered together.
//   clk       in   1       system clock
//   rst       in   1       synchronous active-high reset
//   value     in   32      number to display
//   dp        in   DIGITS  decimal point per digit (bit0 = rightmost)
//   blank     in   1       1 = all enables inactive
//   en        out  DIGITS  one-hot digit enable at EN_ACTIVE
//   seg       out  7       segments a..g at SEG_ACTIVE
//   seg_dp    out  1       decimal point segment at SEG_ACTIVE
//   conv_done out  1       one-cycle pulse when the buffer is updated
// ---------------------------------------------------------------------------
module dis7seg_mux
  import dis7seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIVIDER    = 256,
  parameter int HEX_MODE   = 0,
  parameter int SIGNED     = 1,
  parameter int ZERO_BLANK = 1,
  parameter int EN_ACTIVE  = 0,
  parameter int SEG_ACTIVE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       value,
  input  logic [DIGITS-1:0] dp,
  input  logic              blank,
  output logic [DIGITS-1:0] en,
  output logic [6:0]        seg,
  output logic              seg_dp,
  output logic              conv_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(DIVIDER);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0]  LAST_PRE = PRE_W'(DIVIDER - 1);
  localparam logic [DIGITS-1:0] EN_OFF   = (EN_ACTIVE != 0) ? '0 : '1;
  localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE != 0) ? 7'h00 : 7'h7F;
  localparam logic              DP_OFF   = (SEG_ACTIVE == 0);

  conv_state_e       state_q, state_d;
  logic [31:0]       mag_q, mag_d;
  logic              neg_q, neg_d;
  logic [39:0]       bcd_q, bcd_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [4:0]        buf_q [DIGITS];
  logic [4:0]        buf_d [DIGITS];
  logic              conv_done_q, conv_done_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;

  logic [39:0]       bcd_adj;
  logic [39:0]       digit_vec;
  logic [3:0]        nib [BCD_NIBBLES];
  int                sig_n;
  int                minus_pos;
  logic              overflow;
  logic [4:0]        code_new [DIGITS];
  logic [6:0]        cur_pattern;
  logic [DIGITS-1:0] onehot;

  assign bcd_adj = dabble_adjust(bcd_q);

  // Glyph build: only meaningful while state_q == DONE.
  always_comb begin
    digit_vec = (HEX_MODE != 0) ? {8'd0, mag_q} : bcd_q;
    sig_n     = 1;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      nib[i] = digit_vec[4*i +: 4];
      if (nib[i] != 4'd0) sig_n = i + 1;
    end
    // A negative number needs one extra position for the minus glyph; with
    // zero padding the minus sits at the leftmost digit, which must be free.
    overflow  = (sig_n + (neg_q ? 1 : 0)) > DIGITS;
    minus_pos = (ZERO_BLANK != 0) ? sig_n : DIGITS - 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (overflow)                  code_new[i] = CODE_MINUS;
      else if (i < sig_n)            code_new[i] = {1'b0, nib[i]};
      else if (neg_q && i == minus_pos) code_new[i] = CODE_MINUS;
      else if (ZERO_BLANK != 0)      code_new[i] = CODE_BLANK;
      else                           code_new[i] = 5'd0;
    end
  end

  // Conversion FSM next state.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    bcd_d       = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    buf_d       = buf_q;
    conv_done_d = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        neg_d     = (SIGNED != 0) && value[31];
        // 0x80000000 negates to itself, which read unsigned is 2147483648.
        mag_d     = neg_d ? (32'd0 - value) : value;
        bcd_d     = '0;
        bit_cnt_d = '0;
        state_d   = (HEX_MODE != 0) ? DONE : SHIFT;
      end
      SHIFT: begin
        bcd_d     = (bcd_adj << 1) | {39'd0, mag_q[31]};
        mag_d     = {mag_q[30:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        buf_d       = code_new;
        conv_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  seg7_glyph u_glyph (
    .code    (buf_q[idx_q]),
    .pattern (cur_pattern)
  );

  // Scan: enable and segments both derive from the current idx_q and are
  // registered in the same edge, so they always change together.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == LAST_PRE) begin
      pre_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
    onehot   = DIGITS'(1) << idx_q;
    en_d     = blank ? EN_OFF : ((EN_ACTIVE != 0) ? onehot : ~onehot);
    seg_d    = (SEG_ACTIVE != 0) ? cur_pattern : ~cur_pattern;
    seg_dp_d = (SEG_ACTIVE != 0) ? dp[idx_q] : ~dp[idx_q];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      conv_done_q <= 1'b0;
      pre_q       <= '0;
      idx_q       <= '0;
      en_q        <= EN_OFF;
      seg_q       <= SEG_OFF;
      seg_dp_q    <= DP_OFF;
      // NOTE: the buffer is a few flops, not a RAM macro, so resetting it is
      // cheap and guarantees blank digits until the first conversion lands.
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= CODE_BLANK;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      conv_done_q <= conv_done_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      seg_q       <= seg_d;
      seg_dp_q    <= seg_dp_d;
      buf_q       <= buf_d;
    end
  end

  assign en        = en_q;
  assign seg       = seg_q;
  assign seg_dp    = seg_dp_q;
  assign conv_done = conv_done_q;

endmodule

// File: tb/tb_dis7seg_mux.sv
// ---------------------------------------------------------------------------
// tb_dis7seg_mux
// Three configurations of dis7seg_mux share the inputs:
//   dec: 4 digits, decimal, signed, leading-zero blanking, en active-low
//   hex: 4 digits, hex, unsigned, zero padding
//   alt: 6 digits, decimal, signed, zero padding, inverted pin polarities
// A per-cycle monitor checks scan order/timing, reset, blank, dp and the
// conv_done period; inside settled windows it also checks every digit glyph
// against a digit-string reference model.
// ---------------------------------------------------------------------------
module tb_dis7seg_mux;

  typedef logic [7:0][6:0] pats_t;
  localparam logic [6:0] DASH = 7'b1000000;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        blank;

  logic [3:0] dec_en, hex_en;
  logic [5:0] alt_en;
  logic [6:0] dec_seg, hex_seg, alt_seg;
  logic       dec_dp, hex_dp, alt_dp;
  logic       dec_done, hex_done, alt_done;

  int    n_checks = 0;
  int    n_errors = 0;
  logic  glyph_win;
  pats_t exp_dec, exp_hex, exp_alt;
  int    cur_d [3];
  int    run_l [3];
  int    done_cnt [3];
  bit    fresh [3];

  dis7seg_mux #(.DIGITS(4), .DIVIDER(4), .HEX_MODE(0), .SIGNED(1), .ZERO_BLANK(1),
                .EN_ACTIVE(0), .SEG_ACTIVE(1)) u_dec (
    .clk(clk), .rst(rst), .value(value), .dp(dp[3:0]), .blank(blank),
    .en(dec_en), .seg(dec_seg), .seg_dp(dec_dp), .conv_done(dec_done));

  dis7seg_mux #(.DIGITS(4), .DIVIDER(4), .HEX_MODE(1), .SIGNED(0), .ZERO_BLANK(0),
                .EN_ACTIVE(0), .SEG_ACTIVE(1)) u_hex (
    .clk(clk), .rst(rst), .value(value), .dp(dp[3:0]), .blank(blank),
    .en(hex_en), .seg(hex_seg), .seg_dp(hex_dp), .conv_done(hex_done));

  dis7seg_mux #(.DIGITS(6), .DIVIDER(3), .HEX_MODE(0), .SIGNED(1), .ZERO_BLANK(0),
                .EN_ACTIVE(1), .SEG_ACTIVE(0)) u_alt (
    .clk(clk), .rst(rst), .value(value), .dp(dp[5:0]), .blank(blank),
    .en(alt_en), .seg(alt_seg), .seg_dp(alt_dp), .conv_done(alt_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] tb_glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
     12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Reference: write the magnitude out as a digit string, then place it.
  function automatic pats_t model(input logic [31:0] v, input int digits, input bit hex,
                                  input bit sgn, input bit zb);
    longint m;
    bit     neg;
    int     base;
    int     n;
    int     dig[$];
    pats_t  p;
    neg  = sgn && v[31];
    m    = {32'd0, v};
    if (neg) m = 64'h1_0000_0000 - m;
    base = hex ? 16 : 10;
    do begin
      dig.push_back(int'(m % base));
      m = m / base;
    end while (m != 0);
    n = dig.size();
    p = '0;
    for (int i = 0; i < digits; i++) begin
      if (n + int'(neg) > digits)               p[i] = DASH;
      else if (i < n)                           p[i] = tb_glyph(dig[i]);
      else if (neg && i == (zb ? n : digits-1)) p[i] = DASH;
      else if (zb)                              p[i] = 7'h00;
      else                                      p[i] = tb_glyph(0);
    end
    return p;
  endfunction

  task automatic set_value(input logic [31:0] v);
    value   = v;
    exp_dec = model(v, 4, 1'b0, 1'b1, 1'b1);
    exp_hex = model(v, 4, 1'b1, 1'b0, 1'b0);
    exp_alt = model(v, 6, 1'b0, 1'b1, 1'b0);
  endtask

  // Per-cycle monitor for one DUT; outputs arrive normalised to active-high.
  task automatic mon(input int id, input string nm, input int digits, input int div,
                     input int period, input logic [7:0] en_n, input logic [6:0] seg_n,
                     input logic dp_n, input logic done, input pats_t exp);
    if (rst) begin
      check({nm, "_rst_en"}, en_n, 0);
      check({nm, "_rst_seg"}, seg_n, 0);
      check({nm, "_rst_dp"}, dp_n, 0);
      check({nm, "_rst_done"}, done, 0);
      cur_d[id]    = 0;
      run_l[id]    = 0;
      done_cnt[id] = 0;
      fresh[id]    = 1'b1;
    end else begin
      done_cnt[id]++;
      if (done || done_cnt[id] == period) begin
        check({nm, "_conv_done_period"}, {done, done_cnt[id] == period}, 2'b11);
        done_cnt[id] = 0;
      end
      if (run_l[id] == div) begin
        run_l[id] = 1;
        cur_d[id] = (cur_d[id] + 1) % digits;
      end else begin
        run_l[id]++;
      end
      if (blank) begin
        check({nm, "_blank_en"}, en_n, 0);
      end else begin
        check({nm, "_scan_en"}, en_n, 32'(1) << cur_d[id]);
        check({nm, "_seg_dp"}, dp_n, dp[cur_d[id]]);
        if (fresh[id])      check({nm, "_blank_buffer"}, seg_n, 0);
        else if (glyph_win) check({nm, "_glyph"}, seg_n, exp[cur_d[id]]);
      end
      if (done) fresh[id] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    #2;
    mon(0, "dec", 4, 4, 35, {4'b0, ~dec_en}, dec_seg, dec_dp, dec_done, exp_dec);
    mon(1, "hex", 4, 4, 3, {4'b0, ~hex_en}, hex_seg, hex_dp, hex_done, exp_hex);
    mon(2, "alt", 6, 3, 35, {2'b0, alt_en}, ~alt_seg, ~alt_dp, alt_done, exp_alt);
  end

  task automatic run_value(input logic [31:0] v);
    @(negedge clk);
    glyph_win = 1'b0;
    set_value(v);
    dp = 8'($urandom);
    repeat (75) @(negedge clk);
    glyph_win = 1'b1;
    repeat (40) @(negedge clk);
    glyph_win = 1'b0;
  endtask

  task automatic wait_dec_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (dec_done) break;
    end
    check("wait_dec_conv_done", k < 100, 1);
  endtask

  logic [31:0] dir [12];

  initial begin
    rst = 1'b1; value = '0; dp = '0; blank = 1'b0; glyph_win = 1'b0;
    exp_dec = '0; exp_hex = '0; exp_alt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    dir = '{32'd1234, 32'(-42), 32'd0, 32'd10000, 32'(-1000), 32'(-999),
            32'h8000_0000, 32'h0000_BEEF, 32'h0001_BEEF, 32'd99999,
            32'(-99999), 32'(-100000)};
    foreach (dir[i]) run_value(dir[i]);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      run_value(v);
    end

    // Blank: enables drop while the scan keeps advancing underneath.
    @(negedge clk);
    blank = 1'b1;
    repeat (7) @(negedge clk);
    blank = 1'b0;
    repeat (10) @(negedge clk);

    // Atomicity: change 5 -> 9 one cycle after LOAD.
    begin
      pats_t old_p, new_p;
      int    pulses;
      bit    new_ph;
      int    d;
      @(negedge clk);
      dp = '0;
      set_value(32'd5);
      repeat (75) @(negedge clk);
      wait_dec_done();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      set_value(32'd9);
      old_p  = model(32'd5, 4, 1'b0, 1'b1, 1'b1);
      new_p  = model(32'd9, 4, 1'b0, 1'b1, 1'b1);
      pulses = 0;
      new_ph = 1'b0;
      for (int c = 0; c < 90; c++) begin
        @(posedge clk);
        #2;
        if ($onehot(~dec_en)) begin
          d = 0;
          for (int i = 0; i < 4; i++) if (dec_en[i] == 1'b0) d = i;
          check("atomic_seg", dec_seg, new_ph ? new_p[d] : old_p[d]);
        end
        if (dec_done) begin
          pulses++;
          if (pulses == 2) new_ph = 1'b1;
        end
      end
      check("atomic_pulses", pulses, 2);
    end

    // Reset in the middle of SHIFT, then let the display recover.
    @(negedge clk);
    wait_dec_done();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (75) @(negedge clk);
    glyph_win = 1'b1;
    repeat (40) @(negedge clk);
    glyph_win = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
